// File: rtl/vram_rd_port.sv
// CPU read responder for the display memories: latches read addresses from td4 I/O writes,
// fetches a text-buffer or SDRAM byte via req/ack, and returns data/status on I/O reads. Option: VRDP_AUTOINC_EN.
module vram_rd_port #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic [7:0]  ioad,
    input  logic [15:0] iowdt,
    input  logic        iow,
    input  logic        ior,
    output logic [15:0] iordt,
    output logic        tb_rreq,
    output logic [10:0] tb_raddr,
    input  logic        tb_rack,
    input  logic [7:0]  tb_rdata,
    output logic        sd_rreq,
    output logic [23:0] sd_raddr,
    input  logic        sd_rack,
    input  logic [15:0] sd_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, TB_WAIT, SD_WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [10:0]   taddr, taddr_nxt;
    logic [23:0]   saddr, saddr_nxt;
    logic          busy, valid, err, ovr;
    logic [7:0]    rbyte;
    logic          wr18, wr19, wr1a, rd1b, rd1c;
    logic          start_tb, start_sd, ovr_set;

`ifdef VRDP_AUTOINC_EN
    typedef enum logic [1:0] {K_NONE, K_TB, K_SD} kind_t;
    kind_t last_kind;
`endif

    assign wr18 = iow && (ioad == 8'h18);
    assign wr19 = iow && (ioad == 8'h19);
    assign wr1a = iow && (ioad == 8'h1A);
    assign rd1b = ior && (ioad == 8'h1B);
    assign rd1c = ior && (ioad == 8'h1C);

    assign tb_raddr = taddr;
    assign sd_raddr = {1'b0, saddr[23:1]};

    // Writes and reads share ioad, so a fetch-start write and a $1C read never coincide.
    always_comb begin
        start_tb  = 1'b0;
        start_sd  = 1'b0;
        ovr_set   = 1'b0;
        taddr_nxt = iowdt[10:0];
        saddr_nxt = {saddr[23:16], iowdt};
        if (wr18 || wr1a) begin
            if (busy) ovr_set = 1'b1;
            else begin
                start_tb = wr18;
                start_sd = wr1a;
            end
        end
`ifdef VRDP_AUTOINC_EN
        else if (rd1c) begin
            if (busy) ovr_set = 1'b1;
            else if (last_kind == K_TB) begin
                start_tb  = 1'b1;
                taddr_nxt = taddr + 11'd1;
            end else if (last_kind == K_SD) begin
                start_sd  = 1'b1;
                saddr_nxt = saddr + 24'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            taddr   <= '0;
            saddr   <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            err     <= 1'b0;
            ovr     <= 1'b0;
            rbyte   <= 8'h00;
            iordt   <= 16'h0000;
            tb_rreq <= 1'b0;
            sd_rreq <= 1'b0;
`ifdef VRDP_AUTOINC_EN
            last_kind <= K_NONE;
`endif
        end else begin
            // Status is captured from the pre-edge register values.
            iordt <= 16'h0000;
            if (rd1b)      iordt <= {12'd0, ovr, err, valid, busy};
            else if (rd1c) iordt <= {8'd0, rbyte};

            if (ovr_set)   ovr <= 1'b1;
            else if (rd1b) ovr <= 1'b0;

            if (start_sd)  saddr <= saddr_nxt;
            else if (wr19) saddr[23:16] <= iowdt[7:0];
            if (start_tb)  taddr <= taddr_nxt;

            if (start_tb || start_sd) begin
                busy  <= 1'b1;
                valid <= 1'b0;
                err   <= 1'b0;
                cnt   <= '0;
`ifdef VRDP_AUTOINC_EN
                last_kind <= start_tb ? K_TB : K_SD;
`endif
            end

            case (state)
                IDLE: begin
                    if (start_tb) begin
                        state   <= TB_WAIT;
                        tb_rreq <= 1'b1;
                    end else if (start_sd) begin
                        state   <= SD_WAIT;
                        sd_rreq <= 1'b1;
                    end
                end
                TB_WAIT, SD_WAIT: begin
                    if ((state == TB_WAIT && tb_rack) || (state == SD_WAIT && sd_rack) ||
                        cnt == CW'(TIMEOUT - 1)) begin
                        if (state == TB_WAIT && tb_rack) begin
                            rbyte <= tb_rdata;
                        end else if (state == SD_WAIT && sd_rack) begin
                            rbyte <= saddr[0] ? sd_rdata[15:8] : sd_rdata[7:0];
                        end else begin
                            rbyte <= 8'hFF;
                            err   <= 1'b1;
                        end
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        tb_rreq <= 1'b0;
                        sd_rreq <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_rd_port.sv
// Directed bench for vram_rd_port: table of I/O and handshake steps plus hand-written
// sequences for reset-mid-fetch and the $1C side effects.
module tb_vram_rd_port;
    logic        clk50 = 1'b0;
    logic        reset;
    logic [7:0]  ioad;
    logic [15:0] iowdt;
    logic        iow, ior;
    logic [15:0] iordt;
    logic        tb_rreq, sd_rreq;
    logic [10:0] tb_raddr;
    logic [23:0] sd_raddr;
    logic        tb_rack, sd_rack;
    logic [7:0]  tb_rdata;
    logic [15:0] sd_rdata;

    int checks = 0;
    int failures = 0;

    vram_rd_port #(.TIMEOUT(64)) dut (
        .clk50(clk50), .reset(reset), .ioad(ioad), .iowdt(iowdt), .iow(iow), .ior(ior),
        .iordt(iordt), .tb_rreq(tb_rreq), .tb_raddr(tb_raddr), .tb_rack(tb_rack),
        .tb_rdata(tb_rdata), .sd_rreq(sd_rreq), .sd_raddr(sd_raddr), .sd_rack(sd_rack),
        .sd_rdata(sd_rdata)
    );

    always #5 clk50 = ~clk50;

    typedef enum {OP_W, OP_R, OP_TACK, OP_SACK, OP_TMO, OP_TPULSE, OP_SPULSE} op_e;
    // TACK/SACK: d = cycles to wait after req, exp = ack data, xaddr = expected req address.
    // TMO: d = expected number of cycles req stays high.
    typedef struct {
        op_e         op;
        logic [7:0]  ad;
        logic [15:0] d;
        logic [15:0] exp;
        logic [23:0] xaddr;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(op_e op, logic [7:0] ad, logic [15:0] d, logic [15:0] exp,
                                logic [23:0] xaddr, string name);
        vec_t v;
        v.op = op; v.ad = ad; v.d = d; v.exp = exp; v.xaddr = xaddr; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(logic [7:0] ad, logic [15:0] d);
        ioad = ad; iowdt = d; iow = 1'b1;
        @(negedge clk50);
        iow = 1'b0;
    endtask

    task automatic do_read(logic [7:0] ad, logic [15:0] exp, string name);
        ioad = ad; ior = 1'b1;
        @(negedge clk50);
        ior = 1'b0;
        chk(name, iordt, exp);
    endtask

    task automatic wait_req(string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (tb_rreq || sd_rreq) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk50);
        end
        if (!ok) begin
            failures++;
            checks++;
            $display("FAIL %s_req: got no request expected a request", name);
        end
    endtask

    task automatic pulse_tb(logic [7:0] d);
        tb_rack = 1'b1; tb_rdata = d;
        @(negedge clk50);
        tb_rack = 1'b0;
    endtask

    task automatic pulse_sd(logic [15:0] d);
        sd_rack = 1'b1; sd_rdata = d;
        @(negedge clk50);
        sd_rack = 1'b0;
    endtask

    task automatic run_vec(vec_t v);
        bit ok;
        int n;
        case (v.op)
            OP_W: do_write(v.ad, v.d);
            OP_R: begin
                do_read(v.ad, v.exp, v.name);
`ifdef VRDP_AUTOINC_EN
                // A $1C read restarts the fetch; feed back the same byte so later rows hold.
                if (v.ad == 8'h1C) begin
                    if (tb_rreq) pulse_tb(v.exp[7:0]);
                    else if (sd_rreq) pulse_sd({v.exp[7:0], v.exp[7:0]});
                end
`endif
            end
            OP_TACK, OP_SACK: begin
                wait_req(v.name, ok);
                if (ok) begin
                    if (v.op == OP_TACK) chk({v.name, "_addr"}, 32'(tb_raddr), 32'(v.xaddr));
                    else                 chk({v.name, "_addr"}, 32'(sd_raddr), 32'(v.xaddr));
                    repeat (int'(v.d)) @(negedge clk50);
                    if (v.op == OP_TACK) pulse_tb(v.exp[7:0]);
                    else                 pulse_sd(v.exp);
                    chk({v.name, "_drop"}, {31'd0, tb_rreq | sd_rreq}, 32'd0);
                end
            end
            OP_TMO: begin
                wait_req(v.name, ok);
                n = 0;
                while ((tb_rreq || sd_rreq) && n < 200) begin
                    n++;
                    @(negedge clk50);
                end
                chk(v.name, 32'(n), 32'(v.d));
            end
            OP_TPULSE: pulse_tb(v.exp[7:0]);
            OP_SPULSE: pulse_sd(v.exp);
            default: ;
        endcase
    endtask

    initial begin
        bit ok;
        reset = 1'b1; ioad = 8'h00; iowdt = 16'h0000; iow = 1'b0; ior = 1'b0;
        tb_rack = 1'b0; tb_rdata = 8'h00; sd_rack = 1'b0; sd_rdata = 16'h0000;
        repeat (3) @(negedge clk50);
        chk("rst_iordt", 32'(iordt), 32'd0);
        chk("rst_tb_rreq", {31'd0, tb_rreq}, 32'd0);
        chk("rst_sd_rreq", {31'd0, sd_rreq}, 32'd0);
        chk("rst_tb_raddr", 32'(tb_raddr), 32'd0);
        chk("rst_sd_raddr", 32'(sd_raddr), 32'd0);
        reset = 1'b0;
        @(negedge clk50);
        do_read(8'h1B, 16'h0000, "rst_status");

        add(OP_W,    8'h18, 16'h007B, 16'h0000, 24'h0,      "w18");
        add(OP_R,    8'h1B, 16'h0,    16'h0001, 24'h0,      "busy_status");
        add(OP_TACK, 8'h00, 16'd3,    16'h0041, 24'h00007B, "tb_ack");
        add(OP_R,    8'h1B, 16'h0,    16'h0002, 24'h0,      "tb_status");
        add(OP_R,    8'h1C, 16'h0,    16'h0041, 24'h0,      "tb_byte");
        add(OP_W,    8'h19, 16'h0012, 16'h0000, 24'h0,      "w19");
        add(OP_W,    8'h1A, 16'h3457, 16'h0000, 24'h0,      "w1a_odd");
        add(OP_SACK, 8'h00, 16'd2,    16'hBEEF, 24'h091A2B, "sd_odd");
        add(OP_R,    8'h1C, 16'h0,    16'h00BE, 24'h0,      "sd_hi_byte");
        add(OP_W,    8'h1A, 16'h3456, 16'h0000, 24'h0,      "w1a_even");
        add(OP_SACK, 8'h00, 16'd0,    16'hBEEF, 24'h091A2B, "sd_even");
        add(OP_R,    8'h1C, 16'h0,    16'h00EF, 24'h0,      "sd_lo_byte");
        add(OP_W,    8'h1A, 16'h0001, 16'h0000, 24'h0,      "w1a_x");
        add(OP_TPULSE, 8'h00, 16'h0,  16'h0077, 24'h0,      "stray_tb_ack");
        add(OP_SACK, 8'h00, 16'd1,    16'hA55A, 24'h090000, "sd_x");
        add(OP_R,    8'h1C, 16'h0,    16'h00A5, 24'h0,      "stray_ignored");
        add(OP_W,    8'h18, 16'h0005, 16'h0000, 24'h0,      "w18_tmo");
        add(OP_TMO,  8'h00, 16'd64,   16'h0000, 24'h0,      "timeout_len");
        add(OP_R,    8'h1B, 16'h0,    16'h0006, 24'h0,      "tmo_status");
        add(OP_R,    8'h1C, 16'h0,    16'h00FF, 24'h0,      "tmo_byte");
        add(OP_W,    8'h18, 16'h0010, 16'h0000, 24'h0,      "w18_a");
        add(OP_W,    8'h18, 16'h0100, 16'h0000, 24'h0,      "w18_busy");
        add(OP_R,    8'h1B, 16'h0,    16'h0009, 24'h0,      "ovr_set");
        add(OP_R,    8'h1B, 16'h0,    16'h0001, 24'h0,      "ovr_clr");
        add(OP_TACK, 8'h00, 16'd1,    16'h0022, 24'h000010, "ovr_addr_kept");
        add(OP_R,    8'h1C, 16'h0,    16'h0022, 24'h0,      "ovr_byte");
        add(OP_SPULSE, 8'h00, 16'h0,  16'h1111, 24'h0,      "idle_sd_ack");
        add(OP_R,    8'h1B, 16'h0,    16'h0002, 24'h0,      "idle_ack_status");
        add(OP_R,    8'h1C, 16'h0,    16'h0022, 24'h0,      "idle_ack_byte");
        add(OP_W,    8'h18, 16'h0020, 16'h0000, 24'h0,      "w18_race");
        add(OP_TACK, 8'h00, 16'd63,   16'h003C, 24'h000020, "ack_vs_tmo");
        add(OP_R,    8'h1B, 16'h0,    16'h0002, 24'h0,      "race_status");
        add(OP_R,    8'h1C, 16'h0,    16'h003C, 24'h0,      "race_byte");
        add(OP_W,    8'h17, 16'h1234, 16'h0000, 24'h0,      "w17");
        add(OP_R,    8'h1B, 16'h0,    16'h0002, 24'h0,      "w17_ignored");
        add(OP_W,    8'h1A, 16'h0000, 16'h0000, 24'h0,      "w1a_b");
        add(OP_W,    8'h1A, 16'h0010, 16'h0000, 24'h0,      "w1a_busy");
        add(OP_W,    8'h19, 16'h0034, 16'h0000, 24'h0,      "w19_busy");
        add(OP_R,    8'h1B, 16'h0,    16'h0009, 24'h0,      "sd_ovr");
        add(OP_SACK, 8'h00, 16'd0,    16'h00C3, 24'h1A0000, "sd_hi_update");
        add(OP_R,    8'h1C, 16'h0,    16'h00C3, 24'h0,      "sd_ovr_byte");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during SD_WAIT: req drops next cycle, a late ack is discarded.
        do_write(8'h1A, 16'h0000);
        chk("mid_req_up", {31'd0, sd_rreq}, 32'd1);
        reset = 1'b1;
        @(negedge clk50);
        chk("mid_rst_drop", {31'd0, sd_rreq}, 32'd0);
        chk("mid_rst_addr", 32'(sd_raddr), 32'd0);
        reset = 1'b0;
        pulse_sd(16'hFFFF);
        do_read(8'h1B, 16'h0000, "late_ack_status");
        do_read(8'h1C, 16'h0000, "late_ack_byte");

`ifdef VRDP_AUTOINC_EN
        do_write(8'h18, 16'h07FF);
        wait_req("ai", ok);
        pulse_tb(8'h99);
        do_read(8'h1C, 16'h0099, "ai_old_byte");
        chk("ai_req", {31'd0, tb_rreq}, 32'd1);
        chk("ai_wrap", 32'(tb_raddr), 32'd0);
        do_read(8'h1C, 16'h0099, "ai_busy_byte");
        chk("ai_busy_addr", 32'(tb_raddr), 32'd0);
        do_read(8'h1B, 16'h0009, "ai_busy_ovr");
        pulse_tb(8'h5A);
        do_read(8'h1B, 16'h0002, "ai_done");
`else
        do_read(8'h1C, 16'h0000, "noai_byte");
        chk("noai_no_fetch", {30'd0, tb_rreq, sd_rreq}, 32'd0);
        do_read(8'h1B, 16'h0000, "noai_status");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
